iic_txn_seq: RTL and testbench

IIC_TXN_SEQ -- requirements
Module: iic_txn_seq

---
 rtl/iic_pkg.sv | 36 +++
 rtl/iic_txn_seq_if.sv | 35 +++
 rtl/iic_txn_byte_sel.sv | 41 ++++
 rtl/iic_txn_seq.sv | 191 +++++++++++++++++++
 tb/tb_iic_txn_seq.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/iic_pkg.sv
// Shared definitions for the iic block family: transaction FSM states,
// byte-step indices and the filler byte clocked out while reading.
package iic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BYTE_REQ,
    BYTE_WAIT,
    STOP_REQ,
    STOP_WAIT,
    DONE
  } txn_state_t;

  typedef logic [2:0] step_t;

  localparam step_t STEP_DEV_W = 3'd0;
  localparam step_t STEP_REG   = 3'd1;
  localparam step_t STEP_WDATA = 3'd2;
  localparam step_t STEP_DEV_R = 3'd3;
  localparam step_t STEP_RDATA = 3'd4;

  localparam logic [7:0] RD_FILLER = 8'hFF;

  typedef struct packed {
    logic       rw;
    logic [6:0] dev;
    logic [7:0] reg_addr;
    logic [7:0] wdata;
  } txn_req_t;

  // A read skips the write-data step and restarts with the read address.
  function automatic step_t step_after(step_t s, logic rw);
    return (rw && s == STEP_REG) ? STEP_DEV_R : step_t'(s + 3'd1);
  endfunction

endpackage

// File: rtl/iic_txn_seq_if.sv
// Request/response handshake plus the iic_core command/status bus.
interface iic_txn_seq_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_rw;
  logic [6:0] req_dev;
  logic [7:0] req_reg;
  logic [7:0] req_wdata;
  logic       resp_valid;
  logic [7:0] resp_rdata;
  logic       resp_err;
  logic       core_start;
  logic       core_stop;
  logic       core_rw;
  logic [7:0] core_din;
  logic       core_busy;
  logic       core_sending;
  logic [7:0] core_dout;

  // Client side: issues requests and hosts the iic_core.
  modport master (
    output req_valid, req_rw, req_dev, req_reg, req_wdata,
    output core_busy, core_sending, core_dout,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  core_start, core_stop, core_rw, core_din
  );

  // Sequencer side.
  modport slave (
    input  req_valid, req_rw, req_dev, req_reg, req_wdata,
    input  core_busy, core_sending, core_dout,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output core_start, core_stop, core_rw, core_din
  );
endinterface

// File: rtl/iic_txn_byte_sel.sv
// Maps a byte step plus the captured request to the byte the core sends,
// its direction, and whether a STOP (and end of transaction) follows it.
module iic_txn_byte_sel
  import iic_pkg::*;
(
  input  step_t      step,
  input  txn_req_t   req,
  output logic [7:0] din,
  output logic       rw,
  output logic       stop_after,
  output logic       last
);

  always_comb begin
    din        = 8'h00;
    rw         = 1'b0;
    stop_after = 1'b0;
    last       = 1'b0;
    case (step)
      STEP_DEV_W: din = {req.dev, 1'b0};
      STEP_REG: begin
        din        = req.reg_addr;
        stop_after = req.rw;
      end
      STEP_WDATA: begin
        din        = req.wdata;
        stop_after = 1'b1;
        last       = 1'b1;
      end
      STEP_DEV_R: din = {req.dev, 1'b1};
      STEP_RDATA: begin
        din        = RD_FILLER;
        rw         = 1'b1;
        stop_after = 1'b1;
        last       = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/iic_txn_seq.sv
// Register read/write transaction sequencer driving an iic_core byte engine,
// with a per-handshake timeout that aborts via a single STOP.
module iic_txn_seq
  import iic_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic          clock,
  input  logic          reset,
  iic_txn_seq_if.slave  bus
);

  localparam int WCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT_CYCLES - 1);

  txn_state_t     state;
  step_t          step;
  step_t          sel_step;
  logic [WCW-1:0] wait_cnt;
  txn_req_t       cap;
  txn_req_t       sel_req;

  logic [7:0] sel_din;
  logic       sel_rw, sel_stop, sel_last;
  logic       byte_stop_q, byte_last_q, final_stop, aborting;
  logic       req_ready_q, resp_valid_q, resp_err_q;
  logic [7:0] resp_rdata_q;
  logic       core_start_q, core_stop_q, core_rw_q;
  logic [7:0] core_din_q;
  logic       accept, timeout;

  assign accept  = bus.req_valid && req_ready_q;
  assign timeout = (wait_cnt == WAIT_LAST);

  // Selector looks at the step about to be entered so the byte registers
  // load on the same edge that raises core_start.
  always_comb begin
    sel_req  = cap;
    sel_step = step;
    if (state == IDLE) begin
      sel_req.rw       = bus.req_rw;
      sel_req.dev      = bus.req_dev;
      sel_req.reg_addr = bus.req_reg;
      sel_req.wdata    = bus.req_wdata;
      sel_step         = STEP_DEV_W;
    end else if (state == BYTE_WAIT) begin
      sel_step = step_after(step, cap.rw);
    end
  end

  iic_txn_byte_sel u_byte_sel (
    .step       (sel_step),
    .req        (sel_req),
    .din        (sel_din),
    .rw         (sel_rw),
    .stop_after (sel_stop),
    .last       (sel_last)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      step         <= STEP_DEV_W;
      wait_cnt     <= '0;
      cap          <= '0;
      byte_stop_q  <= 1'b0;
      byte_last_q  <= 1'b0;
      final_stop   <= 1'b0;
      aborting     <= 1'b0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 8'h00;
      core_start_q <= 1'b0;
      core_stop_q  <= 1'b0;
      core_rw_q    <= 1'b0;
      core_din_q   <= 8'h00;
    end else begin
      wait_cnt     <= wait_cnt + 1'b1;
      resp_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          wait_cnt    <= '0;
          req_ready_q <= 1'b1;
          if (accept) begin
            cap          <= sel_req;
            step         <= STEP_DEV_W;
            resp_err_q   <= 1'b0;
            aborting     <= 1'b0;
            req_ready_q  <= 1'b0;
            core_start_q <= 1'b1;
            core_din_q   <= sel_din;
            core_rw_q    <= sel_rw;
            byte_stop_q  <= sel_stop;
            byte_last_q  <= sel_last;
            state        <= BYTE_REQ;
          end
        end
        BYTE_REQ: begin
          if (bus.core_busy && bus.core_sending) begin
            core_start_q <= 1'b0;
            wait_cnt     <= '0;
            state        <= BYTE_WAIT;
          end else if (timeout) begin
            core_start_q <= 1'b0;
            core_stop_q  <= 1'b1;
            resp_err_q   <= 1'b1;
            aborting     <= 1'b1;
            wait_cnt     <= '0;
            state        <= STOP_REQ;
          end
        end
        BYTE_WAIT: begin
          if (!bus.core_busy) begin
            if (core_rw_q) resp_rdata_q <= bus.core_dout;
            wait_cnt <= '0;
            if (byte_stop_q) begin
              step        <= step_after(step, cap.rw);
              final_stop  <= byte_last_q;
              core_stop_q <= 1'b1;
              state       <= STOP_REQ;
            end else begin
              step         <= sel_step;
              core_start_q <= 1'b1;
              core_din_q   <= sel_din;
              core_rw_q    <= sel_rw;
              byte_stop_q  <= sel_stop;
              byte_last_q  <= sel_last;
              state        <= BYTE_REQ;
            end
          end else if (timeout) begin
            core_stop_q <= 1'b1;
            resp_err_q  <= 1'b1;
            aborting    <= 1'b1;
            wait_cnt    <= '0;
            state       <= STOP_REQ;
          end
        end
        STOP_REQ: begin
          if (!bus.core_sending) begin
            core_stop_q <= 1'b0;
            wait_cnt    <= '0;
            state       <= STOP_WAIT;
          end else if (timeout) begin
            wait_cnt <= '0;
            if (aborting) begin
              core_stop_q  <= 1'b0;
              resp_valid_q <= 1'b1;
              state        <= DONE;
            end else begin
              // Give the STOP one more timeout window before giving up.
              resp_err_q <= 1'b1;
              aborting   <= 1'b1;
              state      <= STOP_REQ;
            end
          end
        end
        STOP_WAIT: begin
          wait_cnt <= '0;
          if (final_stop || aborting) begin
            resp_valid_q <= 1'b1;
            state        <= DONE;
          end else begin
            core_start_q <= 1'b1;
            core_din_q   <= sel_din;
            core_rw_q    <= sel_rw;
            byte_stop_q  <= sel_stop;
            byte_last_q  <= sel_last;
            state        <= BYTE_REQ;
          end
        end
        DONE: begin
          wait_cnt    <= '0;
          req_ready_q <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.core_start = core_start_q;
  assign bus.core_stop  = core_stop_q;
  assign bus.core_rw    = core_rw_q;
  assign bus.core_din   = core_din_q;

endmodule

// File: tb/tb_iic_txn_seq.sv
// Directed bench for iic_txn_seq with a small iic_core stand-in.
module tb_iic_txn_seq;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  iic_txn_seq_if bus();

  iic_txn_seq #(.TIMEOUT_CYCLES(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Core stand-in: a start becomes busy+sending for 3 cycles.
  logic core_en;
  int   busy_cnt;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.core_busy    <= 1'b0;
      bus.core_sending <= 1'b0;
      busy_cnt         <= 0;
    end else if (!core_en) begin
      bus.core_busy    <= 1'b0;
      bus.core_sending <= 1'b0;
    end else if (bus.core_busy) begin
      if (busy_cnt == 1) begin
        bus.core_busy    <= 1'b0;
        bus.core_sending <= 1'b0;
      end
      busy_cnt <= busy_cnt - 1;
    end else if (bus.core_start) begin
      bus.core_busy    <= 1'b1;
      bus.core_sending <= 1'b1;
      busy_cnt         <= 3;
    end
  end

  // Event log: byte value (+512 when read direction), 256 for a STOP.
  int ev[$];
  int resp_edges[$];
  int acc_edges[$];
  int cyc = 0;
  int resp_cnt = 0;
  int acc_cnt = 0;
  int overlap = 0;
  logic [7:0] last_rdata;
  logic last_err;
  logic stop_q = 1'b0;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (reset) begin
      stop_q <= 1'b0;
    end else begin
      if (bus.core_start && bus.core_busy && bus.core_sending)
        ev.push_back(int'(bus.core_din) + (bus.core_rw ? 512 : 0));
      if (bus.core_stop && !stop_q) ev.push_back(256);
      stop_q <= bus.core_stop;
      if (bus.core_start && bus.core_stop) overlap <= overlap + 1;
      if (bus.resp_valid) begin
        resp_cnt   <= resp_cnt + 1;
        last_rdata <= bus.resp_rdata;
        last_err   <= bus.resp_err;
        resp_edges.push_back(cyc);
      end
      if (bus.req_valid && bus.req_ready) begin
        acc_cnt <= acc_cnt + 1;
        acc_edges.push_back(cyc);
      end
    end
  end

  function automatic logic [20:0] out_vec();
    return {bus.req_ready, bus.resp_valid, bus.resp_err, bus.resp_rdata,
            bus.core_start, bus.core_stop, bus.core_rw, bus.core_din};
  endfunction

  function automatic int ev_at(int i);
    return (i < ev.size()) ? ev[i] : -1;
  endfunction

  task automatic send(input logic rw, input logic [6:0] dev,
                      input logic [7:0] r, input logic [7:0] wd);
    int a0, n;
    @(negedge clock);
    bus.req_rw = rw; bus.req_dev = dev; bus.req_reg = r; bus.req_wdata = wd;
    bus.req_valid = 1'b1;
    a0 = acc_cnt;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (acc_cnt == a0 && n < 50);
    bus.req_valid = 1'b0;
    if (acc_cnt == a0) begin
      vectors++; miscompares++;
      $display("FAIL accept_timeout: request not accepted within 50 cycles");
    end
  endtask

  task automatic wait_resp(input int target, input int budget);
    int n = 0;
    while (resp_cnt < target && n < budget) begin
      @(negedge clock);
      n++;
    end
    vectors++;
    if (resp_cnt < target) begin
      miscompares++;
      $display("FAIL resp_timeout: got %0d responses, need %0d", resp_cnt, target);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    vectors++;
    if (out_vec() !== 21'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h need 000000", out_vec());
    end
    reset = 1'b0;
    @(negedge clock);
    vectors++;
    if (bus.req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_after_reset: got %b need 1", bus.req_ready);
    end
  endtask

  task automatic test_write();
    int b = ev.size();
    int r0 = resp_cnt;
    int exp_ev[4] = '{32'h7A, 32'h10, 32'hA5, 256};
    send(1'b0, 7'h3D, 8'h10, 8'hA5);
    wait_resp(r0 + 1, 100);
    repeat (3) @(negedge clock);
    vectors++;
    if (ev.size() - b !== 4) begin
      miscompares++;
      $display("FAIL write_ev_count: got %0d need 4", ev.size() - b);
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (ev_at(b + i) !== exp_ev[i]) begin
        miscompares++;
        $display("FAIL write_ev[%0d]: got %h need %h", i, ev_at(b + i), exp_ev[i]);
      end
    end
    vectors++;
    if (last_err !== 1'b0) begin
      miscompares++;
      $display("FAIL write_err: got %b need 0", last_err);
    end
    vectors++;
    if (resp_cnt !== r0 + 1) begin
      miscompares++;
      $display("FAIL write_resp_pulses: got %0d need %0d", resp_cnt - r0, 1);
    end
  endtask

  task automatic test_read();
    int b = ev.size();
    int r0 = resp_cnt;
    int exp_ev[6] = '{32'h7A, 32'h20, 256, 32'h7B, 32'h2FF, 256};
    send(1'b1, 7'h3D, 8'h20, 8'h00);
    wait_resp(r0 + 1, 200);
    vectors++;
    if (ev.size() - b !== 6) begin
      miscompares++;
      $display("FAIL read_ev_count: got %0d need 6", ev.size() - b);
    end
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (ev_at(b + i) !== exp_ev[i]) begin
        miscompares++;
        $display("FAIL read_ev[%0d]: got %h need %h", i, ev_at(b + i), exp_ev[i]);
      end
    end
    vectors++;
    if (last_rdata !== 8'h5C || last_err !== 1'b0) begin
      miscompares++;
      $display("FAIL read_resp: got rdata=%h err=%b need rdata=5c err=0", last_rdata, last_err);
    end
  endtask

  task automatic test_timeout();
    int b = ev.size();
    int r0 = resp_cnt;
    int st = 0, sp = 0, n = 0;
    core_en = 1'b0;
    send(1'b0, 7'h11, 8'h22, 8'h33);
    while (resp_cnt == r0 && n < 60) begin
      if (bus.core_start) st++;
      if (bus.core_stop) sp++;
      @(negedge clock);
      n++;
    end
    vectors++;
    if (resp_cnt !== r0 + 1) begin
      miscompares++;
      $display("FAIL timeout_resp: got %0d responses need 1", resp_cnt - r0);
    end
    vectors++;
    if (st !== 16) begin
      miscompares++;
      $display("FAIL timeout_start_cycles: got %0d need 16", st);
    end
    vectors++;
    if (sp !== 1 || ev.size() - b !== 1 || ev_at(b) !== 256) begin
      miscompares++;
      $display("FAIL timeout_stop: got stop_cycles=%0d events=%0d need 1 STOP only", sp, ev.size() - b);
    end
    vectors++;
    if (last_err !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_err: got %b need 1", last_err);
    end
    vectors++;
    if (last_rdata !== 8'h5C) begin
      miscompares++;
      $display("FAIL rdata_hold: got %h need 5c", last_rdata);
    end
    vectors++;
    if (bus.req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_idle: req_ready got %b need 1", bus.req_ready);
    end
    core_en = 1'b1;
  endtask

  task automatic test_back_to_back();
    int b = ev.size();
    int r0 = resp_cnt;
    int a0 = acc_cnt;
    int n = 0;
    int exp_ev[8] = '{32'h7A, 32'h10, 32'hA5, 256, 32'h24, 32'h34, 32'h56, 256};
    @(negedge clock);
    bus.req_rw = 1'b0; bus.req_dev = 7'h3D; bus.req_reg = 8'h10; bus.req_wdata = 8'hA5;
    bus.req_valid = 1'b1;
    while (acc_cnt == a0 && n < 50) begin @(negedge clock); n++; end
    vectors++;
    if (bus.resp_err !== 1'b0) begin
      miscompares++;
      $display("FAIL err_clear_on_accept: got %b need 0", bus.resp_err);
    end
    bus.req_dev = 7'h12; bus.req_reg = 8'h34; bus.req_wdata = 8'h56;
    n = 0;
    while (acc_cnt < a0 + 2 && n < 200) begin @(negedge clock); n++; end
    bus.req_valid = 1'b0;
    wait_resp(r0 + 2, 200);
    repeat (4) @(negedge clock);
    vectors++;
    if (acc_cnt !== a0 + 2 || resp_cnt !== r0 + 2) begin
      miscompares++;
      $display("FAIL b2b_counts: got accepts=%0d resps=%0d need 2 and 2", acc_cnt - a0, resp_cnt - r0);
    end else begin
      vectors++;
      if (acc_edges[a0 + 1] !== resp_edges[r0] + 1) begin
        miscompares++;
        $display("FAIL b2b_latency: accept at %0d need %0d", acc_edges[a0 + 1], resp_edges[r0] + 1);
      end
    end
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (ev_at(b + i) !== exp_ev[i]) begin
        miscompares++;
        $display("FAIL b2b_ev[%0d]: got %h need %h", i, ev_at(b + i), exp_ev[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int b = ev.size();
    int r0 = resp_cnt;
    int n = 0;
    int b2;
    send(1'b1, 7'h3D, 8'h20, 8'h00);
    while (ev.size() - b < 2 && n < 50) begin @(negedge clock); n++; end
    vectors++;
    if (ev.size() - b !== 2 || bus.core_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_setup: got events=%0d busy=%b need 2 and 1", ev.size() - b, bus.core_busy);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (out_vec() !== 21'h0) begin
      miscompares++;
      $display("FAIL mid_reset_outputs: got %h need 000000", out_vec());
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    vectors++;
    if (resp_cnt !== r0 || ev.size() - b !== 2) begin
      miscompares++;
      $display("FAIL mid_abandon: got resps=%0d events=%0d need 0 and 2", resp_cnt - r0, ev.size() - b);
    end
    b2 = ev.size();
    send(1'b0, 7'h3D, 8'h10, 8'hA5);
    wait_resp(r0 + 1, 100);
    repeat (2) @(negedge clock);
    vectors++;
    if (ev.size() - b2 !== 4 || ev_at(b2) !== 32'h7A || ev_at(b2 + 2) !== 32'hA5) begin
      miscompares++;
      $display("FAIL mid_restart: got events=%0d first=%h third=%h need 4,7a,a5",
               ev.size() - b2, ev_at(b2), ev_at(b2 + 2));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0; bus.req_rw = 1'b0; bus.req_dev = 7'h0;
    bus.req_reg = 8'h0; bus.req_wdata = 8'h0; bus.core_dout = 8'h5C;
    core_en = 1'b1;
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    vectors++;
    if (overlap !== 0) begin
      miscompares++;
      $display("FAIL start_stop_overlap: got %0d cycles need 0", overlap);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
